// File: rtl/mrnw_rdrsp_buf.sv
// Read-response buffer: issues reads to a fixed-latency memory core, tags them through a
// shift pipeline and queues the returned data in a credit-protected show-ahead FIFO.
module mrnw_rdrsp_buf #(
  parameter int WIDTH   = 32,
  parameter int BITADDR = 13,
  parameter int BITPADR = 15,
  parameter int RD_LAT  = 2,
  parameter int FIFODEP = 4,
  parameter int BITFIFO = 3,
  parameter int BITTAG  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ready,
  input  logic               req_vld,
  output logic               req_rdy,
  input  logic [BITADDR-1:0] req_adr,
  input  logic [BITTAG-1:0]  req_tag,
  output logic               read,
  output logic [BITADDR-1:0] rd_adr,
  input  logic               rd_vld,
  input  logic [WIDTH-1:0]   rd_dout,
  input  logic               rd_fwrd,
  input  logic               rd_serr,
  input  logic               rd_derr,
  input  logic [BITPADR-1:0] rd_padr,
  output logic               rsp_vld,
  input  logic               rsp_rdy,
  output logic [WIDTH-1:0]   rsp_dout,
  output logic [BITTAG-1:0]  rsp_tag,
  output logic               rsp_fwrd,
  output logic [1:0]         rsp_err,
  output logic [BITPADR-1:0] rsp_padr,
  output logic [BITFIFO-1:0] credit,
  output logic               lat_err
);

  localparam int BITPTR = (FIFODEP > 1) ? $clog2(FIFODEP) : 1;
  localparam int ENT_W  = WIDTH + BITTAG + 3 + BITPADR;
  localparam int BITGRD = $clog2(RD_LAT + 1);

  logic [BITTAG:0]      pipe [RD_LAT];
  logic [ENT_W-1:0]     mem  [FIFODEP];
  logic [BITPTR-1:0]    wr_ptr, rd_ptr;
  logic [BITFIFO-1:0]   cnt, inflight;
  logic [BITFIFO-1:0]   cnt_nxt, infl_nxt, credit_nxt;
  logic [BITGRD-1:0]    guard;
  logic                 exit_vld, guard_done, push, pop, proto_err;
  logic [BITTAG-1:0]    exit_tag;

  function automatic logic [BITPTR-1:0] ptr_inc(input logic [BITPTR-1:0] p);
    return (p == BITPTR'(FIFODEP - 1)) ? '0 : p + BITPTR'(1);
  endfunction

  assign req_rdy = ready & rst & (credit != '0);
  assign read    = req_vld & req_rdy;
  assign rd_adr  = req_adr;

  assign exit_vld   = pipe[RD_LAT-1][BITTAG];
  assign exit_tag   = pipe[RD_LAT-1][BITTAG-1:0];
  // Returns from reads issued before reset land inside the guard window and are ignored.
  assign guard_done = (guard == '0);
  assign push       = rd_vld & exit_vld & guard_done;
  assign proto_err  = guard_done & (rd_vld != exit_vld);

  assign rsp_vld = rst & (cnt != '0);
  assign pop     = rsp_vld & rsp_rdy;
  assign {rsp_dout, rsp_tag, rsp_fwrd, rsp_err, rsp_padr} = mem[rd_ptr];

  always_comb begin
    cnt_nxt = cnt;
    case ({push, pop})
      2'b10:   cnt_nxt = cnt + BITFIFO'(1);
      2'b01:   cnt_nxt = cnt - BITFIFO'(1);
      default: cnt_nxt = cnt;
    endcase
    infl_nxt = inflight;
    case ({read, exit_vld})
      2'b10:   infl_nxt = inflight + BITFIFO'(1);
      2'b01:   infl_nxt = inflight - BITFIFO'(1);
      default: infl_nxt = inflight;
    endcase
    // Credit follows next-state counts so req_rdy never lags a consumed slot.
    credit_nxt = BITFIFO'(FIFODEP) - infl_nxt - cnt_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      inflight <= '0;
      credit   <= BITFIFO'(FIFODEP);
      lat_err  <= 1'b0;
      guard    <= BITGRD'(RD_LAT);
    end else begin
      pipe[0] <= {read, req_tag};
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      cnt      <= cnt_nxt;
      inflight <= infl_nxt;
      credit   <= credit_nxt;
      if (proto_err) lat_err <= 1'b1;
      if (!guard_done) guard <= guard - BITGRD'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {rd_dout, exit_tag, rd_fwrd, rd_derr, rd_serr, rd_padr};
  end

endmodule

// File: tb/tb_mrnw_rdrsp_buf.sv
// Bench for mrnw_rdrsp_buf: an ideal fixed-latency core model feeds returns, and a
// scoreboard queue of expected responses is checked by an independent monitor.
module tb_mrnw_rdrsp_buf;
  localparam int WIDTH = 32, BITADDR = 13, BITPADR = 15, RD_LAT = 2;
  localparam int FIFODEP = 4, BITFIFO = 3, BITTAG = 4;

  logic               clk = 1'b0;
  logic               rst, ready, req_vld, req_rdy, read, rd_vld, rd_fwrd, rd_serr, rd_derr;
  logic [BITADDR-1:0] req_adr, rd_adr;
  logic [BITTAG-1:0]  req_tag, rsp_tag;
  logic [WIDTH-1:0]   rd_dout, rsp_dout;
  logic [BITPADR-1:0] rd_padr, rsp_padr;
  logic               rsp_vld, rsp_rdy, rsp_fwrd, lat_err;
  logic [1:0]         rsp_err;
  logic [BITFIFO-1:0] credit;

  mrnw_rdrsp_buf #(.WIDTH(WIDTH), .BITADDR(BITADDR), .BITPADR(BITPADR), .RD_LAT(RD_LAT),
                   .FIFODEP(FIFODEP), .BITFIFO(BITFIFO), .BITTAG(BITTAG)) dut (
    .clk(clk), .rst(rst), .ready(ready), .req_vld(req_vld), .req_rdy(req_rdy),
    .req_adr(req_adr), .req_tag(req_tag), .read(read), .rd_adr(rd_adr),
    .rd_vld(rd_vld), .rd_dout(rd_dout), .rd_fwrd(rd_fwrd), .rd_serr(rd_serr),
    .rd_derr(rd_derr), .rd_padr(rd_padr), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
    .rsp_dout(rsp_dout), .rsp_tag(rsp_tag), .rsp_fwrd(rsp_fwrd), .rsp_err(rsp_err),
    .rsp_padr(rsp_padr), .credit(credit), .lat_err(lat_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                 due;
    logic [WIDTH-1:0]   dout;
    logic [BITTAG-1:0]  tag;
    logic               fwrd, serr, derr;
    logic [BITPADR-1:0] padr;
  } item_t;

  item_t pend[$];
  item_t sb[$];
  int total = 0, bad = 0, cyc = 0, acc_cnt = 0;
  logic               hold_nx;
  logic [WIDTH-1:0]   nx_dout;
  logic               nx_fwrd, nx_serr, nx_derr;
  logic [BITPADR-1:0] nx_padr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic new_nx();
    nx_dout = $urandom;
    nx_fwrd = 1'($urandom_range(0, 1));
    nx_serr = 1'($urandom_range(0, 1));
    nx_derr = 1'($urandom_range(0, 1));
    nx_padr = BITPADR'($urandom);
  endtask

  // Ends the current cycle (recording any accepted read) and drives core returns for the next.
  task automatic tick();
    @(negedge clk);
    if (read === 1'b1) begin
      item_t it;
      it.due  = cyc + RD_LAT;
      it.tag  = req_tag;
      it.dout = nx_dout;
      it.fwrd = nx_fwrd;
      it.serr = nx_serr;
      it.derr = nx_derr;
      it.padr = nx_padr;
      pend.push_back(it);
      sb.push_back(it);
      acc_cnt++;
      if (!hold_nx) new_nx();
    end
    @(posedge clk);
    #1;
    cyc++;
    rd_vld = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      rd_vld  = 1'b1;
      rd_dout = pend[0].dout;
      rd_fwrd = pend[0].fwrd;
      rd_serr = pend[0].serr;
      rd_derr = pend[0].derr;
      rd_padr = pend[0].padr;
      void'(pend.pop_front());
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    pend.delete();
    sb.delete();
    tick();
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("sb_bound", 64'(sb.size() <= FIFODEP), 64'd1);
      if (rsp_vld === 1'b1) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_vld), 64'd0);
        end else begin
          chk("rsp_head", {rsp_dout, rsp_tag, rsp_fwrd, rsp_err, rsp_padr},
              {sb[0].dout, sb[0].tag, sb[0].fwrd, sb[0].derr, sb[0].serr, sb[0].padr});
          if (rsp_rdy === 1'b1) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; ready = 1'b1; req_vld = 1'b1; req_adr = '0; req_tag = '0;
    rd_vld = 1'b0; rd_dout = '0; rd_fwrd = 1'b0; rd_serr = 1'b0; rd_derr = 1'b0; rd_padr = '0;
    rsp_rdy = 1'b1; hold_nx = 1'b0; new_nx();
    tick(); tick();
    chk("rst_req_rdy", 64'(req_rdy), 64'd0);
    chk("rst_read", 64'(read), 64'd0);
    chk("rst_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("rst_credit", 64'(credit), 64'd4);
    req_vld = 1'b0; rst = 1'b1; #1;
    chk("rst_rel_req_rdy", 64'(req_rdy), 64'd1);
    chk("rst_rel_lat_err", 64'(lat_err), 64'd0);
    ready = 1'b0; req_vld = 1'b1; #1;
    chk("notready_req_rdy", 64'(req_rdy), 64'd0);
    chk("notready_read", 64'(read), 64'd0);
    req_vld = 1'b0; ready = 1'b1;
    repeat (3) tick();

    // single read, fixed data
    hold_nx = 1'b1; nx_dout = 32'hA5A5A5A5; nx_fwrd = 1'b0; nx_serr = 1'b0; nx_derr = 1'b0;
    nx_padr = '0;
    req_vld = 1'b1; req_tag = 4'd5; req_adr = 13'h10; #1;
    chk("single_read", 64'(read), 64'd1);
    chk("single_rd_adr", 64'(rd_adr), 64'h10);
    tick(); req_vld = 1'b0;
    chk("single_credit_c1", 64'(credit), 64'd3);
    tick();
    chk("single_credit_c2", 64'(credit), 64'd3);
    chk("single_rsp_vld_c2", 64'(rsp_vld), 64'd0);
    tick();
    chk("single_credit_c3", 64'(credit), 64'd3);
    chk("single_rsp_vld_c3", 64'(rsp_vld), 64'd1);
    chk("single_rsp_tag", 64'(rsp_tag), 64'd5);
    chk("single_rsp_dout", 64'(rsp_dout), 64'hA5A5A5A5);
    tick();
    chk("single_credit_c4", 64'(credit), 64'd4);
    chk("single_rsp_vld_c4", 64'(rsp_vld), 64'd0);
    hold_nx = 1'b0; new_nx();

    // backpressure
    rsp_rdy = 1'b0; acc_cnt = 0; req_vld = 1'b1;
    for (int i = 0; i < 12; i++) begin
      req_tag = BITTAG'($urandom); req_adr = BITADDR'($urandom);
      tick();
    end
    req_vld = 1'b0;
    chk("bp_accepted", 64'(acc_cnt), 64'd4);
    chk("bp_req_rdy", 64'(req_rdy), 64'd0);
    chk("bp_credit", 64'(credit), 64'd0);
    chk("bp_rsp_vld", 64'(rsp_vld), 64'd1);
    chk("bp_lat_err", 64'(lat_err), 64'd0);
    rsp_rdy = 1'b1;
    repeat (8) tick();
    chk("bp_drained", 64'(sb.size()), 64'd0);
    chk("bp_credit_after", 64'(credit), 64'd4);

    // full FIFO with simultaneous push and pop
    rsp_rdy = 1'b0; req_vld = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      req_tag = BITTAG'(i);
      tick();
    end
    req_vld = 1'b0;
    repeat (3) tick();
    chk("full_pre_credit", 64'(credit), 64'd1);
    req_vld = 1'b1; req_tag = 4'd4;
    tick(); req_vld = 1'b0;
    chk("full_credit0", 64'(credit), 64'd0);
    tick(); rsp_rdy = 1'b1;
    chk("full_ret_rd_vld", 64'(rd_vld), 64'd1);
    chk("full_ret_credit", 64'(credit), 64'd0);
    tick(); rsp_rdy = 1'b0;
    chk("full_after_rsp_vld", 64'(rsp_vld), 64'd1);
    chk("full_after_credit", 64'(credit), 64'd1);
    chk("full_after_head_tag", 64'(rsp_tag), 64'd2);
    rsp_rdy = 1'b1;
    repeat (6) tick();
    chk("full_drained", 64'(sb.size()), 64'd0);

    // error passthrough
    hold_nx = 1'b1; nx_dout = $urandom; nx_fwrd = 1'b1; nx_serr = 1'b1; nx_derr = 1'b0;
    nx_padr = 15'h1234; rsp_rdy = 1'b0;
    req_vld = 1'b1; req_tag = 4'd9;
    tick(); req_vld = 1'b0;
    tick(); tick();
    chk("err_rsp_vld", 64'(rsp_vld), 64'd1);
    chk("err_rsp_err", 64'(rsp_err), 64'b01);
    chk("err_rsp_fwrd", 64'(rsp_fwrd), 64'd1);
    chk("err_rsp_padr", 64'(rsp_padr), 64'h1234);
    rsp_rdy = 1'b1;
    tick();
    hold_nx = 1'b0; new_nx();
    chk("err_drained", 64'(sb.size()), 64'd0);

    // stray return with nothing in flight
    do_reset();
    repeat (5) tick();
    rd_vld = 1'b1;
    tick();
    chk("proto_lat_err", 64'(lat_err), 64'd1);
    chk("proto_credit", 64'(credit), 64'd4);
    chk("proto_rsp_vld", 64'(rsp_vld), 64'd0);
    repeat (5) tick();
    chk("proto_sticky", 64'(lat_err), 64'd1);
    do_reset();
    chk("proto_rst_clear", 64'(lat_err), 64'd0);
    chk("proto_rst_credit", 64'(credit), 64'd4);

    // reset with reads in flight, late return after release
    repeat (3) tick();
    req_vld = 1'b1; req_tag = 4'd3;
    tick(); req_tag = 4'd6;
    tick(); req_vld = 1'b0;
    do_reset();
    tick();
    rd_vld = 1'b1; rd_dout = $urandom;
    tick();
    repeat (4) tick();
    chk("midrst_lat_err", 64'(lat_err), 64'd0);
    chk("midrst_credit", 64'(credit), 64'd4);
    chk("midrst_rsp_vld", 64'(rsp_vld), 64'd0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      ready   = ($urandom_range(0, 3) != 0);
      req_vld = 1'($urandom_range(0, 1));
      req_tag = BITTAG'($urandom);
      req_adr = BITADDR'($urandom);
      rsp_rdy = ($urandom_range(0, 9) < 6);
      #1;
      if (read === 1'b1) chk("rand_rd_adr", 64'(rd_adr), 64'(req_adr));
      tick();
    end
    req_vld = 1'b0; ready = 1'b1; rsp_rdy = 1'b1;
    repeat (20) tick();
    chk("rand_drained", 64'(sb.size()), 64'd0);
    chk("rand_lat_err", 64'(lat_err), 64'd0);
    chk("rand_credit", 64'(credit), 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mrnw_rdrsp_buf.md
MRNW_RDRSP_BUF -- requirements
Module: mrnw_rdrsp_buf

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameters SHALL be as follows, one per line (name, default, meaning):
- WIDTH, 32, data width.
- BITADDR, 13, address width.
- BITPADR, 15, physical-address width.
- RD_LAT, 2, fixed cycles from a read strobe to its rd_vld.
- FIFODEP, 4, response FIFO depth.
- BITFIFO, 3, counter width; holds values 0..FIFODEP.
- BITTAG, 4, request tag width.
REQ-003 Ports SHALL be as follows, one per line (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, synchronous active-low reset.
- ready, in, 1, memory core initialised.
- req_vld, in, 1, client read request valid.
- req_rdy, out, 1, request accepted this cycle.
- req_adr, in, BITADDR, read address.
- req_tag, in, BITTAG, client tag.
- read, out, 1, read strobe to the memory core.
- rd_adr, out, BITADDR, read address to the memory core.
- rd_vld, in, 1, read data valid from the core.
- rd_dout, in, WIDTH, read data.
- rd_fwrd, in, 1, data was forwarded.
- rd_serr, in, 1, single-bit error.
- rd_derr, in, 1, double-bit error.
- rd_padr, in, BITPADR, physical address.
- rsp_vld, out, 1, response valid.
- rsp_rdy, in, 1, client accepts the response.
- rsp_dout, out, WIDTH, response data.
- rsp_tag, out, BITTAG, response tag.
- rsp_fwrd, out, 1, forwarded flag.
- rsp_err, out, 2, {derr, serr}.
- rsp_padr, out, BITPADR, physical address.
- credit, out, BITFIFO, free credits.
- lat_err, out, 1, sticky latency-protocol error.

Function
REQ-004 The credit count SHALL equal FIFODEP minus the number of in-flight reads minus the FIFO occupancy; credit SHALL be this value, registered.
REQ-005 req_rdy SHALL be combinational: ready & rst & (credit != 0).
REQ-006 read SHALL be req_vld & req_rdy, and rd_adr SHALL equal req_adr; read and rd_adr SHALL be combinational, with zero added latency.
REQ-007 Each accepted request SHALL enter a tag shift pipeline RD_LAT stages deep, carrying {valid, tag}.
REQ-008 The in-flight count SHALL increment on acceptance and decrement when a valid entry leaves the pipeline; both events in the same cycle SHALL leave it unchanged.
REQ-009 When rd_vld is asserted and the pipeline exit is valid, the block SHALL push {rd_dout, exit tag, rd_fwrd, rd_derr, rd_serr, rd_padr} into the FIFO.
REQ-010 An rd_vld with no valid pipeline exit, or a valid exit with no rd_vld, SHALL set lat_err and SHALL NOT push; the exit entry SHALL be discarded and its credit returned.
REQ-011 The FIFO SHALL be show-ahead: rsp_* SHALL present the head entry whenever occupancy is nonzero, and rsp_vld SHALL be (occupancy != 0).
REQ-012 A pop SHALL occur on rsp_vld & rsp_rdy; head data SHALL stay stable while rsp_vld=1 and rsp_rdy=0.
REQ-013 A simultaneous push and pop SHALL be legal at any occupancy, including full, and SHALL leave occupancy unchanged.
REQ-014 Read and write pointers SHALL wrap modulo FIFODEP; FIFODEP is not required to be a power of two.
REQ-015 Credit accounting SHALL guarantee that no push ever occurs while the FIFO is full; a push at full is a design bug, and the bench asserts that it never happens.
REQ-016 Responses SHALL leave in request order; no reordering is permitted.
REQ-017 ready=0 SHALL block new acceptances only; in-flight reads and FIFO draining SHALL continue.
REQ-018 A post-reset guard counter SHALL suppress lat_err detection for RD_LAT cycles after reset deasserts, so that returns from reads issued before reset are ignored; rd_vld during the guard window SHALL neither push nor set lat_err.

Reset
REQ-019 While rst=0, at the clock edge: pointers, occupancy, in-flight count and the tag pipeline SHALL clear, lat_err SHALL clear, and credit SHALL become FIFODEP.
REQ-020 During reset, req_rdy, read, and rsp_vld SHALL be 0, and rsp_dout/rsp_tag may hold stale RAM contents.
REQ-021 Reset asserted mid-operation SHALL discard all in-flight reads and buffered responses without emitting them.

Verification
REQ-022 Single read (RD_LAT=2): tag 5, adr 0x10 accepted at cycle 0, rd_vld with dout 0xA5A5A5A5 at cycle 2 -> rsp_vld=1 at cycle 3 with tag 5 and that data; credit reads 3 over cycles 1..3 and 4 after the pop.
REQ-023 Backpressure: rsp_rdy=0 with req_vld=1 continuously -> exactly 4 reads accepted; req_rdy=0 thereafter; the FIFO holds 4 entries; no lat_err.
REQ-024 Full with simultaneous push/pop: credit=0, FIFO at 3 entries with 1 in flight, rsp_rdy=1 on the return cycle -> occupancy stays 3 and tags emerge in order.
REQ-025 Protocol error: rd_vld pulse with nothing in flight, 5 cycles after reset -> lat_err=1 and stays 1 until reset; FIFO unchanged; credit stays 4.
REQ-026 Reset mid-flight: 2 reads issued, rst=0 for one cycle, and the core returns rd_vld 1 cycle after reset release -> no response, lat_err=0, credit=4.
REQ-027 Error passthrough: rd_serr=1, rd_derr=0, rd_fwrd=1, rd_padr=0x1234 -> rsp_err=2'b01, rsp_fwrd=1, rsp_padr=0x1234.
